add_accum_unit: RTL and testbench
=================================

Name: add_accum_unit

Overview:
Parametrised successor to the team's combinational 8-bit adder. It registers add, subtract, accumulate and read-and-clear operations behind a valid/ready handshake, with optional saturation and carry/overflow flags. It sits between a host-side operand source and a result sink, with one result register and an internal accumulator.

Parameters:
WIDTH, 8, operand, result and accumulator width in bits (2..32)
CNT_WIDTH, 4, width of the accumulate-operation counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand/op presented
in_ready  output  1  unit can accept an operation this cycle
a  input  WIDTH  operand A (unsigned; signed view used only for overflow)
b  input  WIDTH  operand B
op  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
sat_en  input  1  saturate result on unsigned carry/borrow; sampled with op
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  sink accepts result
result  output  WIDTH  registered result
carry  output  1  ADD/ACC: unsigned carry-out; SUB: borrow (a<b)
overflow  output  1  two's-complement signed overflow of the unsaturated operation
acc_count  output  CNT_WIDTH  number of ACC ops since reset/CLR; saturates at all-ones

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything. It clears acc, acc_count, result, carry, overflow and out_valid to 0. After reset, in_ready=1. Reset mid-operation discards any pending result.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready. Output consume = out_valid && out_ready.
- Latency is one cycle: an op accepted at edge N drives result/flags with out_valid=1 after edge N.
- Accept and consume in the same cycle both happen. The new result replaces the old one, and out_valid stays 1.
- Consume without accept clears out_valid to 0. result and flags hold their last values.
- While out_valid=1 and out_ready=0: in_ready=0, and result, flags, acc and acc_count are frozen.
- Each result is computed at WIDTH+1 bits: sum = {0,x}+{0,y}; diff = {0,a}-{0,b}.
- ADD: result = sum[WIDTH-1:0] and carry = sum[WIDTH]. If sat_en && carry, result = all-ones.
- SUB: result = diff[WIDTH-1:0] and carry = (a<b). If sat_en && carry, result = 0.
- ACC: x=acc, y=a, b is ignored, and ADD rules apply. acc <= the final (possibly saturated) result. acc_count increments if not all-ones.
- CLR: result = current acc (read-and-clear), carry=0, overflow=0. acc <= 0 and acc_count <= 0. a, b and sat_en are ignored.
- overflow: for ADD/ACC, operands share a sign bit and the raw sum MSB differs. For SUB, operand signs differ and the raw diff MSB differs from a's. It reflects the raw value regardless of sat_en.
- acc and acc_count change only on an accepted ACC or CLR; ADD and SUB never touch them.
- No combinational path from in_valid/a/b/op to any output other than in_ready; in_ready depends only on out_valid and out_ready.

Test Plan:
- Reset, then ADD a=200 b=100 sat_en=0 with out_ready=1 -> next cycle result=44, carry=1, overflow=0, out_valid=1. Repeat with sat_en=1 -> result=255, carry=1.
- SUB a=5 b=9: sat_en=0 -> result=252, carry=1. sat_en=1 -> result=0, carry=1. SUB a=0x80 b=0x01 -> result=0x7F, overflow=1, carry=0.
- ACC a=100 four times, out_ready=1, sat_en=0 -> results 100, 200, 44 (carry=1), 144; acc_count=4. Then CLR -> result=144, acc=0, acc_count=0.
- Backpressure: out_ready=0 after the first ADD -> in_ready=0, and held in_valid ACC ops change neither acc nor result for 5 cycles. Raise out_ready -> the pending op is accepted in that same cycle, and its result appears on the next cycle.
- Streaming: in_valid=1 and out_ready=1 continuously, ADD a=i b=i for i=0..9 -> one result per cycle, result=2i, out_valid stays 1 throughout.
- Mid-stream reset: assert rst for one cycle with an ACC in flight and acc=77 -> out_valid=0, acc_count=0, and a following ACC a=3 gives result=3.

Source files
------------

// File: rtl/add_accum_unit.sv
// add_accum_unit: registered add / subtract / accumulate / read-and-clear unit
// with a valid/ready handshake on both sides, optional unsigned saturation,
// and carry/overflow flags. One result register, one internal accumulator.
module add_accum_unit #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  input  logic                 sat_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 carry,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] acc_count
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  // Clamp to all-ones when an unsigned add carried out and saturation is on.
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] raw,
                                               input logic en,
                                               input logic c);
    sat_add = (en && c) ? {WIDTH{1'b1}} : raw;
  endfunction

  // Clamp to zero when an unsigned subtract borrowed and saturation is on.
  function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] raw,
                                               input logic en,
                                               input logic c);
    sat_sub = (en && c) ? {WIDTH{1'b0}} : raw;
  endfunction

  logic [WIDTH-1:0]        acc_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [WIDTH-1:0]        result_p1;
  logic                    carry_p1;
  logic                    ovf_p1;
  logic                    vld_p1;

  op_e                     op_p0;
  logic [WIDTH-1:0]        x_p0;
  logic [WIDTH-1:0]        y_p0;
  logic signed [WIDTH-1:0] xs_p0;
  logic signed [WIDTH-1:0] ys_p0;
  logic signed [WIDTH-1:0] as_p0;
  logic signed [WIDTH-1:0] bs_p0;
  logic [WIDTH:0]          sum_p0;
  logic [WIDTH:0]          diff_p0;
  logic [WIDTH-1:0]        res_p0;
  logic                    carry_p0;
  logic                    ovf_p0;
  logic                    accept;
  logic                    consume;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = vld_p1 && out_ready;

  // ---- stage p0: operand select and WIDTH+1-bit arithmetic ----
  // Compute the next result and flags for whatever op is currently presented.
  always_comb begin
    op_p0    = op_e'(op);
    x_p0     = (op_p0 == OP_ACC) ? acc_q : a;
    y_p0     = (op_p0 == OP_ACC) ? a : b;
    xs_p0    = signed'(x_p0);
    ys_p0    = signed'(y_p0);
    as_p0    = signed'(a);
    bs_p0    = signed'(b);
    sum_p0   = {1'b0, x_p0} + {1'b0, y_p0};
    diff_p0  = {1'b0, a} - {1'b0, b};
    res_p0   = '0;
    carry_p0 = 1'b0;
    ovf_p0   = 1'b0;
    case (op_p0)
      OP_ADD, OP_ACC: begin
        carry_p0 = sum_p0[WIDTH];
        res_p0   = sat_add(sum_p0[WIDTH-1:0], sat_en, carry_p0);
        ovf_p0   = (xs_p0[WIDTH-1] == ys_p0[WIDTH-1]) &&
                   (sum_p0[WIDTH-1] != xs_p0[WIDTH-1]);
      end
      OP_SUB: begin
        // Borrow out of the extended subtract is exactly a < b.
        carry_p0 = diff_p0[WIDTH];
        res_p0   = sat_sub(diff_p0[WIDTH-1:0], sat_en, carry_p0);
        ovf_p0   = (as_p0[WIDTH-1] != bs_p0[WIDTH-1]) &&
                   (diff_p0[WIDTH-1] != as_p0[WIDTH-1]);
      end
      default: begin
        // Read-and-clear returns the accumulator with clean flags.
        res_p0   = acc_q;
        carry_p0 = 1'b0;
        ovf_p0   = 1'b0;
      end
    endcase
  end

  // ---- stage p1: result register, accumulator and handshake state ----
  // Capture on accept; drop valid on a consume with no new op; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      result_p1 <= '0;
      carry_p1  <= 1'b0;
      ovf_p1    <= 1'b0;
      vld_p1    <= 1'b0;
    end else if (accept) begin
      result_p1 <= res_p0;
      carry_p1  <= carry_p0;
      ovf_p1    <= ovf_p0;
      vld_p1    <= 1'b1;
      if (op_p0 == OP_ACC) begin
        acc_q <= res_p0;
        if (!(&cnt_q)) cnt_q <= cnt_q + 1'b1;
      end else if (op_p0 == OP_CLR) begin
        acc_q <= '0;
        cnt_q <= '0;
      end
    end else if (consume) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign result    = result_p1;
  assign carry     = carry_p1;
  assign overflow  = ovf_p1;
  assign acc_count = cnt_q;

endmodule

// File: tb/tb_add_accum_unit.sv
// Testbench for add_accum_unit: directed test-plan steps followed by random
// traffic, checked against an arithmetic reference model of the unit.
module tb_add_accum_unit;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam longint MOD     = 64'd1 << W;
  localparam longint HALF    = 64'd1 << (W - 1);
  localparam longint CNT_MAX = (64'd1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    op;
  logic          sat_en;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carry;
  logic          overflow;
  logic [CW-1:0] acc_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  longint m_acc, m_cnt, m_res;
  bit     m_valid, m_carry, m_ovf;

  add_accum_unit #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .sat_en(sat_en), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry(carry),
    .overflow(overflow), .acc_count(acc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sval(input longint v);
    return (v >= HALF) ? v - MOD : v;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_res = 0;
    m_valid = 0; m_carry = 0; m_ovf = 0;
  endtask

  // Apply one accepted operation to the model using plain integer arithmetic.
  task automatic model_accept(input int o, input longint av, input longint bv, input bit s);
    longint x, y, t, st;
    case (o)
      0, 2: begin
        x = (o == 2) ? m_acc : av;
        y = (o == 2) ? av : bv;
        t = x + y;
        m_carry = (t >= MOD);
        m_res   = (m_carry && s) ? MOD - 1 : t % MOD;
        st      = sval(x) + sval(y);
        m_ovf   = (st < -HALF) || (st >= HALF);
        if (o == 2) begin
          m_acc = m_res;
          if (m_cnt < CNT_MAX) m_cnt++;
        end
      end
      1: begin
        m_carry = (av < bv);
        m_res   = (m_carry && s) ? 0 : (av - bv + MOD) % MOD;
        st      = sval(av) - sval(bv);
        m_ovf   = (st < -HALF) || (st >= HALF);
      end
      default: begin
        m_res = m_acc; m_carry = 0; m_ovf = 0;
        m_acc = 0; m_cnt = 0;
      end
    endcase
    m_valid = 1;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"}, out_valid, m_valid);
    chk({tag, ".result"},    result,    m_res);
    chk({tag, ".carry"},     carry,     m_carry);
    chk({tag, ".overflow"},  overflow,  m_ovf);
    chk({tag, ".acc_count"}, acc_count, m_cnt);
  endtask

  // One clock cycle: drive inputs just after an edge, check in_ready, step.
  task automatic do_cycle(input string tag, input bit r, input bit iv, input int o,
                          input longint av, input longint bv, input bit s, input bit ordy);
    bit acc_en, cons;
    logic [63:0] av_v, bv_v, o_v;
    av_v = av; bv_v = bv; o_v = o;
    rst = r; in_valid = iv; op = o_v[1:0]; a = av_v[W-1:0]; b = bv_v[W-1:0];
    sat_en = s; out_ready = ordy;
    #1;
    chk({tag, ".in_ready"}, in_ready, (!m_valid || ordy));
    acc_en = iv && (!m_valid || ordy);
    cons   = m_valid && ordy;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else if (acc_en) model_accept(o, av, bv, s);
    else if (cons) m_valid = 0;
    rst = 1'b0;
    check_outs(tag);
  endtask

  logic [W-1:0] held;

  initial begin
    rst = 1'b1; in_valid = 0; op = 0; a = 0; b = 0; sat_en = 0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outs("reset");
    #1;
    chk("reset.in_ready", in_ready, 1'b1);

    // ADD with and without saturation
    do_cycle("add", 0, 1, 0, 200, 100, 0, 1);
    chk("add.const", {result, carry, overflow}, {8'd44, 1'b1, 1'b0});
    do_cycle("add_sat", 0, 1, 0, 200, 100, 1, 1);
    chk("add_sat.const", {result, carry}, {8'd255, 1'b1});

    // SUB borrow / saturation / signed overflow
    do_cycle("sub", 0, 1, 1, 5, 9, 0, 1);
    chk("sub.const", {result, carry}, {8'd252, 1'b1});
    do_cycle("sub_sat", 0, 1, 1, 5, 9, 1, 1);
    chk("sub_sat.const", {result, carry}, {8'd0, 1'b1});
    do_cycle("sub_ovf", 0, 1, 1, 8'h80, 8'h01, 0, 1);
    chk("sub_ovf.const", {result, carry, overflow}, {8'h7F, 1'b0, 1'b1});

    // Accumulate four times from a clean accumulator, then read-and-clear
    do_cycle("clr0", 0, 1, 3, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) do_cycle("acc", 0, 1, 2, 100, 55, 0, 1);
    chk("acc.const", {result, acc_count}, {8'd144, 4'd4});
    do_cycle("clr", 0, 1, 3, 9, 9, 1, 1);
    chk("clr.const", {result, acc_count}, {8'd144, 4'd0});

    // Backpressure: hold an ACC while the sink stalls
    do_cycle("bp_add", 0, 1, 0, 10, 20, 0, 1);
    held = result;
    for (int i = 0; i < 5; i++) do_cycle("bp_hold", 0, 1, 2, 7, 0, 0, 0);
    chk("bp_hold.result", result, held);
    do_cycle("bp_go", 0, 1, 2, 7, 0, 0, 1);
    chk("bp_go.const", {result, acc_count}, {8'd7, 4'd1});

    // Streaming: one result per cycle
    for (int i = 0; i < 10; i++) begin
      do_cycle("stream", 0, 1, 0, i, i, 0, 1);
      chk("stream.const", {out_valid, result}, {1'b1, 8'(2 * i)});
    end
    do_cycle("drain", 0, 0, 0, 0, 0, 0, 1);

    // Mid-stream reset with acc=77
    do_cycle("mr_clr", 0, 1, 3, 0, 0, 0, 1);
    do_cycle("mr_acc", 0, 1, 2, 77, 0, 0, 1);
    do_cycle("mr_rst", 1, 1, 2, 5, 0, 0, 1);
    chk("mr_rst.const", {out_valid, acc_count}, {1'b0, 4'd0});
    do_cycle("mr_acc3", 0, 1, 2, 3, 0, 0, 1);
    chk("mr_acc3.const", result, 8'd3);

    // Counter saturation at all-ones
    for (int i = 0; i < 18; i++) do_cycle("cnt_sat", 0, 1, 2, 1, 0, 1, 1);
    chk("cnt_sat.const", acc_count, 4'hF);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      do_cycle("rand", ($urandom_range(0, 39) == 0), $urandom_range(0, 3) != 0,
               int'($urandom_range(0, 3)), longint'($urandom_range(0, MOD - 1)),
               longint'($urandom_range(0, MOD - 1)), $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
